machine_timer_unit: RTL and testbench

//  Memory-mapped machine timer and software-interrupt source (CLINT subset) for the RV32I-Trap core.

---
 rtl/machine_timer_unit_if.sv | 23 ++
 rtl/machine_timer_unit.sv | 113 +++++++++++
 tb/tb_machine_timer_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/machine_timer_unit_if.sv
// Data-bus view of the machine timer unit.
// The core side (master) drives the strobes, word address, write data and
// byte enables. The timer side (slave) returns combinational read data and
// the window-hit flag that the top-level read-data mux uses.
interface machine_timer_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output mem_read, mem_write, adr, wdata, wmask,
    input  rdata, hit
  );

  modport slave (
    input  mem_read, mem_write, adr, wdata, wmask,
    output rdata, hit
  );
endinterface

// File: rtl/machine_timer_unit.sv
// Machine timer and software-interrupt source (CLINT subset).
// Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip,
// all mapped into a 64 KiB window at BASE_ADDR on the core data bus.
// Ports:
//   clk        core clock
//   rst        asynchronous reset, active-low
//   halt       1 = freeze mtime and the prescaler (bus writes still apply)
//   bus        data-bus slave: mem_read, mem_write, adr, wdata, wmask in;
//              rdata (combinational, 0 unless hit & mem_read), hit out
//   timer_irq  registered (mtime >= mtimecmp), unsigned 64-bit
//   sw_irq     msip register
module machine_timer_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  machine_timer_unit_if.slave  bus,
  output logic                 timer_irq,
  output logic                 sw_irq
);

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;
  localparam logic [15:0] PS_MAX      = 16'(PRESCALE - 1);

  logic [63:0] mtime, mtime_inc, mtime_n;
  logic [63:0] mtimecmp, mtimecmp_n;
  logic        msip, msip_n;
  logic [15:0] pcount, pcount_n;
  logic [15:0] off;
  logic        wr_en;
  logic        tick;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign off    = bus.adr[15:0];
  assign bus.hit = (bus.adr[31:16] == BASE_ADDR[31:16]);
  assign wr_en  = bus.mem_write & bus.hit;
  assign tick   = !halt && (pcount == PS_MAX);
  assign sw_irq = msip;

  always_comb begin
    pcount_n = pcount;
    if (!halt) pcount_n = tick ? 16'd0 : pcount + 16'd1;

    mtime_inc  = tick ? mtime + 64'd1 : mtime;
    mtime_n    = mtime_inc;
    mtimecmp_n = mtimecmp;
    msip_n     = msip;

    if (wr_en) begin
      case (off)
        OFF_MSIP:    if (bus.wmask[0]) msip_n = bus.wdata[0];
        OFF_CMP_LO:  mtimecmp_n[31:0]  = merge_bytes(mtimecmp[31:0],  bus.wdata, bus.wmask);
        OFF_CMP_HI:  mtimecmp_n[63:32] = merge_bytes(mtimecmp[63:32], bus.wdata, bus.wmask);
        // Low-word write: unwritten bytes keep the incremented value, but the
        // high word holds so no carry reaches it this cycle.
        OFF_TIME_LO: mtime_n = {mtime[63:32],
                                merge_bytes(mtime_inc[31:0], bus.wdata, bus.wmask)};
        // High-word write: low word still counts; its carry-out is dropped.
        OFF_TIME_HI: mtime_n = {merge_bytes(mtime[63:32], bus.wdata, bus.wmask),
                                mtime_inc[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip      <= 1'b0;
      pcount    <= 16'd0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_n;
      mtimecmp  <= mtimecmp_n;
      msip      <= msip_n;
      pcount    <= pcount_n;
      // Compare on next-state values so the flag lines up with the registers.
      timer_irq <= (mtime_n >= mtimecmp_n);
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.hit && bus.mem_read) begin
      case (off)
        OFF_MSIP:    bus.rdata = {31'd0, msip};
        OFF_CMP_LO:  bus.rdata = mtimecmp[31:0];
        OFF_CMP_HI:  bus.rdata = mtimecmp[63:32];
        OFF_TIME_LO: bus.rdata = mtime[31:0];
        OFF_TIME_HI: bus.rdata = mtime[63:32];
        default:     bus.rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_timer_unit.sv
module tb_machine_timer_unit;

  localparam logic [31:0] BASE    = 32'h0200_0000;
  localparam logic [31:0] MSIP    = BASE + 32'h0000;
  localparam logic [31:0] CMP_LO  = BASE + 32'h4000;
  localparam logic [31:0] CMP_HI  = BASE + 32'h4004;
  localparam logic [31:0] TIME_LO = BASE + 32'hBFF8;
  localparam logic [31:0] TIME_HI = BASE + 32'hBFFC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt1 = 1'b0;
  logic halt4 = 1'b0;
  logic timer_irq1, sw_irq1, timer_irq4, sw_irq4;

  int n_checks = 0;
  int n_errors = 0;

  machine_timer_unit_if bus1();
  machine_timer_unit_if bus4();

  machine_timer_unit #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .halt(halt1), .bus(bus1),
    .timer_irq(timer_irq1), .sw_irq(sw_irq1)
  );

  machine_timer_unit #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .halt(halt4), .bus(bus4),
    .timer_irq(timer_irq4), .sw_irq(sw_irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge (+small offset); the write commits on the next posedge.
  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus1.adr = a; bus1.wdata = d; bus1.wmask = m; bus1.mem_write = 1'b1;
    @(negedge clk);
    bus1.mem_write = 1'b0;
  endtask

  task automatic rd1(input logic [31:0] a, output logic [31:0] d);
    bus1.adr = a; bus1.mem_read = 1'b1;
    #1;
    d = bus1.rdata;
    bus1.mem_read = 1'b0;
  endtask

  task automatic rd4(input logic [31:0] a, output logic [31:0] d);
    bus4.adr = a; bus4.mem_read = 1'b1;
    #1;
    d = bus4.rdata;
    bus4.mem_read = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bus1.mem_read = 0; bus1.mem_write = 0; bus1.adr = 0; bus1.wdata = 0; bus1.wmask = 0;
    bus4.mem_read = 0; bus4.mem_write = 0; bus4.adr = 0; bus4.wdata = 0; bus4.wmask = 0;

    // Reset held for 3 cycles, reads valid right after release
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd1(TIME_LO, d); check("rst_mtime_lo", d, 0);
    rd1(CMP_HI, d);  check("rst_cmp_hi", d, 32'hFFFF_FFFF);
    check("rst_timer_irq", timer_irq1, 0);
    check("rst_sw_irq", sw_irq1, 0);
    rd4(TIME_LO, d); check("rst_mtime4_lo", d, 0);

    // Prescaler = 4: 40 cycles -> 10 ticks, then halt freezes
    repeat (40) @(negedge clk);
    rd4(TIME_LO, d); check("ps4_40cyc", d, 10);
    halt4 = 1'b1;
    repeat (8) @(negedge clk);
    rd4(TIME_LO, d); check("ps4_halt", d, 10);
    halt4 = 1'b0;
    repeat (4) @(negedge clk);
    rd4(TIME_LO, d); check("ps4_resume", d, 11);

    // Carry from low into high word
    wr1(TIME_HI, 32'h0, 4'hF);
    wr1(TIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd1(TIME_LO, d); check("carry_pre_lo", d, 32'hFFFF_FFFF);
    rd1(TIME_HI, d); check("carry_pre_hi", d, 0);
    @(negedge clk);
    rd1(TIME_LO, d); check("carry_lo", d, 0);
    rd1(TIME_HI, d); check("carry_hi", d, 1);

    // Low write on the carry cycle: high holds
    wr1(TIME_HI, 32'h0, 4'hF);
    wr1(TIME_LO, 32'hFFFF_FFFF, 4'hF);
    wr1(TIME_LO, 32'h5, 4'hF);
    rd1(TIME_HI, d); check("lowr_carry_hi", d, 0);
    rd1(TIME_LO, d); check("lowr_carry_lo", d, 5);

    // High write on the carry cycle: carry dropped, low wraps
    wr1(TIME_HI, 32'h0, 4'hF);
    wr1(TIME_LO, 32'hFFFF_FFFF, 4'hF);
    wr1(TIME_HI, 32'h7, 4'hF);
    rd1(TIME_HI, d); check("hiwr_carry_hi", d, 7);
    rd1(TIME_LO, d); check("hiwr_carry_lo", d, 0);

    // 64-bit wrap; mtimecmp still all-ones so irq follows the wrap
    wr1(TIME_HI, 32'hFFFF_FFFF, 4'hF);
    wr1(TIME_LO, 32'hFFFF_FFFF, 4'hF);
    rd1(TIME_HI, d); check("wrap_pre_hi", d, 32'hFFFF_FFFF);
    check("wrap_pre_irq", timer_irq1, 1);
    @(negedge clk);
    rd1(TIME_LO, d); check("wrap_lo", d, 0);
    rd1(TIME_HI, d); check("wrap_hi", d, 0);
    check("wrap_irq", timer_irq1, 0);

    // Compare: mtimecmp = 0x20, mtime starts at 0x1C
    wr1(CMP_HI, 32'h0, 4'hF);
    wr1(CMP_LO, 32'h20, 4'hF);
    wr1(TIME_HI, 32'h0, 4'hF);
    wr1(TIME_LO, 32'h1C, 4'hF);
    for (int i = 0; i < 6; i++) begin
      rd1(TIME_LO, d); check("cmp_mtime", d, 32'h1C + 32'(i));
      check("cmp_irq", timer_irq1, (i >= 4) ? 1 : 0);
      @(negedge clk);
    end
    wr1(CMP_HI, 32'h1, 4'hF);
    check("cmp_hi_drop", timer_irq1, 0);

    // Byte-masked mtimecmp write
    wr1(CMP_LO, 32'h0000_AB00, 4'b0010);
    rd1(CMP_LO, d); check("cmp_mask_lo", d, 32'h0000_AB20);
    rd1(CMP_HI, d); check("cmp_mask_hi", d, 1);

    // Software interrupt with byte masks
    wr1(MSIP, 32'h1, 4'b0001);
    check("msip_set", sw_irq1, 1);
    rd1(MSIP, d); check("msip_read", d, 1);
    wr1(MSIP, 32'h0, 4'b1110);
    check("msip_mask_hold", sw_irq1, 1);
    wr1(MSIP, 32'h0, 4'b0001);
    check("msip_clr", sw_irq1, 0);
    wr1(MSIP, 32'hFFFF_FFFF, 4'hF);
    rd1(MSIP, d); check("msip_upper_zero", d, 1);
    wr1(MSIP, 32'h0, 4'hF);

    // Decode
    rd1(BASE + 32'h0001_0000, d);
    check("dec_out_rdata", d, 0);
    check("dec_out_hit", bus1.hit, 0);
    wr1(BASE + 32'h0001_0000, 32'hFFFF_FFFF, 4'hF);
    check("dec_out_wr_msip", sw_irq1, 0);
    rd1(BASE + 32'h0008, d);
    check("dec_hole_rdata", d, 0);
    check("dec_hole_hit", bus1.hit, 1);
    wr1(BASE + 32'h4008, 32'hFFFF_FFFF, 4'hF);
    rd1(CMP_LO, d); check("dec_hole_wr", d, 32'h0000_AB20);
    bus1.adr = CMP_LO; bus1.mem_read = 1'b0;
    #1;
    check("noread_rdata", bus1.rdata, 0);
    check("noread_hit", bus1.hit, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
